// File: rtl/cpu_stim_pkg.sv
// Shared types and helpers for the cpu stimulus memory harness.
package cpu_stim_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StWait = 2'd2;
  localparam state_t StDone = 2'd3;

  // Store-log entries carry 32-bit fields; wider datapaths are truncated into them.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  // Byte address to word index; callers zero-extend to 64 bits.
  function automatic logic [63:0] word_idx(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/cpu_stim_mem_sync_fifo.sv
// Synchronous FIFO with sticky overflow flag; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned Aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [Aw:0] FullCount = DEPTH[Aw:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw-1:0]    wptr_q, wptr_d;
  logic [Aw-1:0]    rptr_q, rptr_d;
  logic [Aw:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign rdata    = mem_q[rptr_q];
  assign overflow = overflow_q;

  always_comb begin
    do_pop     = pop && !empty;
    // A same-cycle pop frees the slot, so a push on full still lands.
    do_push    = push && (!full || do_pop);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    if (push && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_stim_mem.sv
// Instruction/data memory harness for the cpu core: loadable program, wait states,
// load/store service and a store log for self-checking benches.
module cpu_stim_mem
  import cpu_stim_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     IMEM_DEPTH  = 64,
  parameter int unsigned     DMEM_DEPTH  = 64,
  parameter int unsigned     LOG_DEPTH   = 8,
  parameter int unsigned     WAIT_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES  = 1024,
  parameter logic [XLEN-1:0] NOP         = XLEN'(NopInst)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]               prog_data,
  input  logic                          wait_en,
  input  logic [XLEN-1:0]               halt_pc,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               d,
  input  logic [XLEN-1:0]               address,
  input  logic                          store,
  input  logic                          load,
  output logic [XLEN-1:0]               inst,
  output logic                          stall,
  output logic [XLEN-1:0]               rdata,
  output logic                          log_valid,
  output logic [XLEN-1:0]               log_addr,
  output logic [XLEN-1:0]               log_data,
  input  logic                          log_pop,
  output logic                          log_overflow,
  output logic [31:0]                   retired,
  output logic                          done,
  output logic                          timeout
);

  localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
  localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);
  localparam int unsigned WaitW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  state_t          state_q, state_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]     retired_q, retired_d;
  logic            timeout_q, timeout_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [63:0]       pc_word, addr_word;
  logic [ImemAw-1:0] imem_idx;
  logic [DmemAw-1:0] dmem_idx;
  logic              fetch_hit, addr_hit, run;
  log_entry_t        log_in, log_head;
  logic              log_empty, log_full;

  assign run       = (state_q == StRun);
  assign pc_word   = word_idx(64'(pc));
  assign addr_word = word_idx(64'(address));
  assign imem_idx  = pc_word[ImemAw-1:0];
  assign dmem_idx  = addr_word[DmemAw-1:0];
  assign fetch_hit = (pc[1:0] == 2'b00) && (pc_word < 64'(IMEM_DEPTH));
  assign addr_hit  = (addr_word < 64'(DMEM_DEPTH));

  always_comb begin
    state_d    = state_q;
    last_pc_d  = last_pc_q;
    wait_cnt_d = wait_cnt_q;
    retired_d  = retired_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          last_pc_d = pc;
        end
      end
      StRun: begin
        retired_d = retired_q + 32'd1;
        // Halt wins over timeout when both land on the same cycle.
        if (pc == halt_pc) begin
          state_d = StDone;
        end else if (retired_d == 32'(MAX_CYCLES)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (wait_en && (WAIT_CYCLES != 0) && (pc != last_pc_q)) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end else begin
          last_pc_d = pc;
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitW'(WAIT_CYCLES - 1)) begin
          state_d   = StRun;
          last_pc_d = pc;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read-before-write: a same-cycle store does not affect the returned word.
  always_comb begin
    rdata_d = rdata_q;
    if (run && load) rdata_d = addr_hit ? dmem[dmem_idx] : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      last_pc_q  <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_pc_q  <= last_pc_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && (state_q == StIdle)) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (run && store && addr_hit) dmem[dmem_idx] <= d;
  end

  assign log_in.addr = 32'(address);
  assign log_in.data = 32'(d);

  sync_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (run && store),
    .pop      (log_pop),
    .wdata    (log_in),
    .rdata    (log_head),
    .full     (log_full),
    .empty    (log_empty),
    .overflow (log_overflow)
  );

  assign inst      = (run && fetch_hit) ? imem[imem_idx] : NOP;
  assign stall     = !run;
  assign rdata     = rdata_q;
  assign log_valid = !log_empty;
  assign log_addr  = XLEN'(log_head.addr);
  assign log_data  = XLEN'(log_head.data);
  assign retired   = retired_q;
  assign done      = (state_q == StDone);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_stim_mem.sv
// Randomised and directed bench for cpu_stim_mem against a queue/array reference model.
module tb_cpu_stim_mem;

  localparam int unsigned IMEM_DEPTH  = 64;
  localparam int unsigned DMEM_DEPTH  = 64;
  localparam int unsigned LOG_DEPTH   = 8;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned MAX_CYCLES  = 16;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] FAR_PC      = 32'hFFFF_FFF0;

  logic        clk, n_rst, start, prog_we, wait_en, store, load, log_pop;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data, halt_pc, pc, d, address;
  logic [31:0] inst, rdata, log_addr, log_data, retired;
  logic        stall, log_valid, log_overflow, done, timeout;

  cpu_stim_mem #(
    .XLEN        (32),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .DMEM_DEPTH  (DMEM_DEPTH),
    .LOG_DEPTH   (LOG_DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .NOP         (NOP)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .wait_en      (wait_en),
    .halt_pc      (halt_pc),
    .pc           (pc),
    .d            (d),
    .address      (address),
    .store        (store),
    .load         (load),
    .inst         (inst),
    .stall        (stall),
    .rdata        (rdata),
    .log_valid    (log_valid),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_pop      (log_pop),
    .log_overflow (log_overflow),
    .retired      (retired),
    .done         (done),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  typedef enum int {MIdle, MRun, MWait, MDone} mphase_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  mphase_e     m_phase;
  int          m_wait_left;
  logic [31:0] m_last_pc;
  int          m_retired;
  bit          m_timeout, m_overflow;
  logic [31:0] m_imem [IMEM_DEPTH];
  logic [31:0] m_dmem [DMEM_DEPTH];
  bit          m_dvalid [DMEM_DEPTH];
  logic [31:0] m_rdata;
  bit          m_rdata_known;
  ent_t        m_log [$];

  task automatic model_reset();
    m_phase       = MIdle;
    m_wait_left   = 0;
    m_last_pc     = '0;
    m_retired     = 0;
    m_timeout     = 1'b0;
    m_overflow    = 1'b0;
    m_rdata       = '0;
    m_rdata_known = 1'b1;
    m_log.delete();
  endtask

  function automatic logic [31:0] exp_inst();
    if (m_phase != MRun) return NOP;
    if (pc[1:0] != 2'b00 || pc >= 4 * IMEM_DEPTH) return NOP;
    return m_imem[pc >> 2];
  endfunction

  task automatic model_step();
    bit run_now, was_full, pop_ok;
    run_now  = (m_phase == MRun);
    was_full = (m_log.size() == LOG_DEPTH);
    pop_ok   = log_pop && (m_log.size() != 0);
    case (m_phase)
      MIdle: begin
        if (prog_we) m_imem[prog_addr] = prog_data;
        if (start) begin
          m_phase   = MRun;
          m_last_pc = pc;
        end
      end
      MRun: begin
        if (load) begin
          if (address < 4 * DMEM_DEPTH) begin
            m_rdata       = m_dmem[address >> 2];
            m_rdata_known = m_dvalid[address >> 2];
          end else begin
            m_rdata       = '0;
            m_rdata_known = 1'b1;
          end
        end
        if (store && address < 4 * DMEM_DEPTH) begin
          m_dmem[address >> 2]   = d;
          m_dvalid[address >> 2] = 1'b1;
        end
        m_retired++;
        if (pc == halt_pc) begin
          m_phase = MDone;
        end else if (m_retired == MAX_CYCLES) begin
          m_phase   = MDone;
          m_timeout = 1'b1;
        end else if (wait_en && pc != m_last_pc) begin
          m_phase     = MWait;
          m_wait_left = WAIT_CYCLES;
        end else begin
          m_last_pc = pc;
        end
      end
      MWait: begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_phase   = MRun;
          m_last_pc = pc;
        end
      end
      default: ;
    endcase
    if (pop_ok) void'(m_log.pop_front());
    if (run_now && store) begin
      if (!was_full || pop_ok) m_log.push_back('{addr: address, data: d});
      else m_overflow = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("stall", 64'(stall), 64'(m_phase != MRun));
    check_eq("inst", 64'(inst), 64'(exp_inst()));
    check_eq("done", 64'(done), 64'(m_phase == MDone));
    check_eq("timeout", 64'(timeout), 64'(m_timeout));
    check_eq("retired", 64'(retired), 64'(m_retired));
    check_eq("log_valid", 64'(log_valid), 64'(m_log.size() != 0));
    check_eq("log_overflow", 64'(log_overflow), 64'(m_overflow));
    if (m_log.size() != 0) begin
      check_eq("log_addr", 64'(log_addr), 64'(m_log[0].addr));
      check_eq("log_data", 64'(log_data), 64'(m_log[0].data));
    end
    if (m_rdata_known) check_eq("rdata", 64'(rdata), 64'(m_rdata));
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  task automatic clear_inputs();
    start = 0; prog_we = 0; prog_addr = '0; prog_data = '0; wait_en = 0;
    halt_pc = FAR_PC; pc = '0; d = '0; address = '0; store = 0; load = 0; log_pop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic prog(input int idx, input logic [31:0] w);
    prog_we = 1; prog_addr = 6'(idx); prog_data = w;
    cycle();
    prog_we = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  logic [31:0] words [4];
  int          n;

  initial begin
    words[0] = 32'h0000_FFB7; words[1] = 32'h7FFF_8F13;
    words[2] = 32'h01FF_0EB3; words[3] = 32'h01EF_80A3;
    n_rst = 1'b0;
    clear_inputs();
    model_reset();

    // Reset state.
    do_reset();
    sample();
    check_eq("rst_stall", 64'(stall), 64'd1);
    check_eq("rst_inst", 64'(inst), 64'(NOP));
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    tick();

    for (int i = 0; i < 4; i++) prog(i, words[i]);
    prog(4, NOP);
    for (int i = 5; i < IMEM_DEPTH; i++) prog(i, $urandom());

    // Basic fetch.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      sample();
      check_eq("fetch_inst", 64'(inst), 64'(words[k]));
      check_eq("fetch_stall", 64'(stall), 64'd0);
      tick();
    end
    pc = 32'd16;
    sample();
    check_eq("fetch_nop", 64'(inst), 64'(NOP));
    check_eq("fetch_retired", 64'(retired), 64'd4);
    tick();

    // Wait states, then asynchronous reset mid-WAIT with a non-empty log.
    do_reset();
    wait_en = 1;
    pulse_start();
    store = 1; address = 32'h8; d = 32'h55;
    sample();
    check_eq("wait_pre_stall", 64'(stall), 64'd0);
    tick();
    store = 0; pc = 32'd4;
    cycle();
    for (int k = 0; k < 2; k++) begin
      sample();
      check_eq("wait_stall_hi", 64'(stall), 64'd1);
      tick();
    end
    sample();
    check_eq("wait_stall_lo", 64'(stall), 64'd0);
    check_eq("wait_inst", 64'(inst), 64'h7FFF_8F13);
    tick();
    pc = 32'd8;
    cycle();
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("arst_stall", 64'(stall), 64'd1);
    check_eq("arst_inst", 64'(inst), 64'(NOP));
    check_eq("arst_log_valid", 64'(log_valid), 64'd0);
    check_eq("arst_retired", 64'(retired), 64'd0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    pulse_start();
    sample();
    check_eq("replay_inst", 64'(inst), 64'h0000_FFB7);
    tick();

    // Store log and load-back.
    do_reset();
    pulse_start();
    store = 1; address = 32'h1;  d = 32'hF7FF;
    cycle();
    address = 32'h20; d = 32'hABCD;
    cycle();
    store = 0;
    sample();
    check_eq("log_head_addr0", 64'(log_addr), 64'h1);
    check_eq("log_head_data0", 64'(log_data), 64'hF7FF);
    log_pop = 1;
    tick();
    log_pop = 0; load = 1; address = 32'h20;
    sample();
    check_eq("log_head_addr1", 64'(log_addr), 64'h20);
    check_eq("log_head_data1", 64'(log_data), 64'hABCD);
    tick();
    load = 0;
    sample();
    check_eq("dmem8", 64'(rdata), 64'hABCD);
    tick();

    // Overflow: nine stores into an eight-entry log.
    do_reset();
    pulse_start();
    store = 1;
    for (int i = 0; i < 9; i++) begin
      address = 32'(i * 4); d = 32'(32'h100 + i);
      cycle();
    end
    store = 0;
    sample();
    check_eq("ovf_flag", 64'(log_overflow), 64'd1);
    tick();
    store = 1; log_pop = 1; address = 32'h40; d = 32'h999;
    cycle();
    store = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!log_valid) break;
      n++;
      tick();
    end
    log_pop = 0;
    check_eq("ovf_occupancy", 64'(n), 64'd8);
    check_eq("ovf_sticky", 64'(log_overflow), 64'd1);
    tick();

    // Halt.
    do_reset();
    halt_pc = 32'h10;
    pulse_start();
    for (int k = 0; k <= 4; k++) begin
      pc = 32'(k * 4);
      cycle();
    end
    pc = 32'd20; start = 1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("halt_done", 64'(done), 64'd1);
      check_eq("halt_timeout", 64'(timeout), 64'd0);
      check_eq("halt_stall", 64'(stall), 64'd1);
      tick();
    end
    start = 0;

    // Timeout.
    do_reset();
    pulse_start();
    repeat (MAX_CYCLES) cycle();
    sample();
    check_eq("to_done", 64'(done), 64'd1);
    check_eq("to_timeout", 64'(timeout), 64'd1);
    check_eq("to_retired", 64'(retired), 64'(MAX_CYCLES));
    tick();

    // Random episodes.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int k = 0; k < 4; k++) prog($urandom_range(0, IMEM_DEPTH - 1), $urandom());
      halt_pc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 12) * 4) : FAR_PC;
      wait_en = ($urandom_range(0, 1) != 0);
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: pc = pc + 32'd4;
          2: pc = 32'($urandom_range(0, 70) * 4);
          default: pc = 32'($urandom_range(0, 300));
        endcase
        store     = ($urandom_range(0, 2) == 0);
        load      = ($urandom_range(0, 2) == 0);
        address   = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 300));
        d         = $urandom();
        log_pop   = ($urandom_range(0, 3) == 0);
        start     = ($urandom_range(0, 7) == 0);
        prog_we   = ($urandom_range(0, 7) == 0);
        prog_addr = 6'($urandom_range(0, IMEM_DEPTH - 1));
        prog_data = $urandom();
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_stim_mem.md
Name: cpu_stim_mem

Overview:
- Parametrised instruction/data memory harness that drives the `cpu` core in simulation and FPGA bring-up.
- Replaces hand-sequenced `inst` stimulus: holds a loadable program and serves `inst` indexed by `pc`.
- Optionally inserts wait states through `stall`, services load/store traffic, and logs stores to a FIFO for self-checking benches.
- Sits beside `cpu`, port-for-port matched to its `inst`/`stall`/`pc`/`d`/`address`/`store`/`load` interface.

Parameters:
- XLEN, 32, datapath and address width.
- IMEM_DEPTH, 64, instruction words (power of two).
- DMEM_DEPTH, 64, data words (power of two).
- LOG_DEPTH, 8, store-log FIFO entries (power of two).
- WAIT_CYCLES, 2, stall cycles inserted per fetch when `wait_en`=1; 0 disables wait states.
- MAX_CYCLES, 1024, RUN-cycle timeout.
- NOP, 32'h00000013, instruction served out of range or outside RUN.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  IDLE->RUN pulse.
- prog_we  in  1  program-buffer write strobe, honoured in IDLE only.
- prog_addr  in  $clog2(IMEM_DEPTH)  word index.
- prog_data  in  XLEN  instruction word.
- wait_en  in  1  enable wait-state insertion.
- halt_pc  in  XLEN  pc value that ends the run.
- pc  in  XLEN  core program counter.
- d  in  XLEN  core store data.
- address  in  XLEN  core data address.
- store  in  1  core store request.
- load  in  1  core load request.
- inst  out  XLEN  instruction to core.
- stall  out  1  core stall.
- rdata  out  XLEN  load data.
- log_valid  out  1  store log not empty.
- log_addr  out  XLEN  head entry address.
- log_data  out  XLEN  head entry data.
- log_pop  in  1  dequeue head entry.
- log_overflow  out  1  sticky; a store was dropped.
- retired  out  32  count of unstalled RUN cycles.
- done  out  1  run finished.
- timeout  out  1  run ended by MAX_CYCLES.

Behaviour:
- **Reset.** One clock `clk`; reset `n_rst` is asynchronous, active-low.
  - State=IDLE; `retired`=0; FIFO empty.
  - `log_overflow`, `done` and `timeout` are 0.
  - Memory contents are not reset.
  - Outputs in reset: `inst`=NOP, `stall`=1, `rdata`=0.
- **States:**
  - IDLE: `stall`=1, `inst`=NOP. `prog_we` writes `prog_data` to `imem[prog_addr]`. `start` -> RUN.
  - RUN: `stall`=0. If `wait_en` and WAIT_CYCLES>0 and `pc`≠`pc_q` (last served pc) -> WAIT.
  - WAIT: `stall`=1 for exactly WAIT_CYCLES cycles, then RUN with `pc_q` updated. `store`/`load` are ignored while in WAIT.
  - DONE: `stall`=1, `inst`=NOP, `done`=1. Held until reset; `start` is ignored.
- **Fetch.** `inst` = `imem[pc[2+:log2 IMEM_DEPTH]]`, combinational, in RUN only.
  - `pc`[1:0]≠0 or `pc`≥4*IMEM_DEPTH -> NOP.
- **Halt.** In RUN, `pc`==`halt_pc` -> DONE next edge. The instruction at `halt_pc` is served for that one cycle.
- **Timeout.** `retired` reaching MAX_CYCLES -> DONE with `timeout`=1. Halt has priority if both occur on the same cycle.
- **Store.** In RUN with `store`=1: `dmem[address word]` <= `d` at the edge.
  - Out-of-range address: memory write dropped, but still logged.
  - Log push of {`address`, `d`}. If FIFO full and no same-cycle pop: entry dropped, `log_overflow` <= 1.
- **Load.** `rdata` registered one cycle after `load`=1: `dmem[address word]`, or 0 if out of range.
  - `store` and `load` in the same cycle: store applies; `rdata` returns the old word (read-before-write).
- **Log FIFO.**
  - Pop on empty is ignored.
  - Simultaneous push and pop on full: both occur; occupancy unchanged.
  - Pointers wrap modulo LOG_DEPTH.
- **Reset mid-RUN** returns to IDLE immediately; `imem` is preserved, so `start` replays the program.

Decomposition:
- Package `cpu_stim_pkg`:
  - state enum {IDLE, RUN, WAIT, DONE};
  - log entry struct {addr, data};
  - NOP constant;
  - `word_idx` function.
- Sub-module `sync_fifo` (parametrised WIDTH/DEPTH, push/pop/full/empty/overflow) implements the store log.

Test Plan:
- **Basic fetch.**
  - Stimulus: load imem[0..3] = 0x0000FFB7, 0x7FFF8F13, 0x01FF0EB3, 0x01EF80A3; `start`; drive `pc`=0,4,8,12.
  - Required: `inst` matches each word with `stall`=0; `pc`=16 -> 0x00000013; `retired`=4.
- **Wait states.**
  - Stimulus: `wait_en`=1, WAIT_CYCLES=2, `pc` steps 0 -> 4.
  - Required: `stall` high exactly 2 cycles after the change, then low with `inst`=0x7FFF8F13.
- **Store log.**
  - Stimulus: store `address`=0x1, `d`=0xF7FF, then store `address`=0x20, `d`=0xABCD.
  - Required: `log_valid`=1; head {0x1, 0xF7FF}; after `log_pop`, head {0x20, 0xABCD}; `dmem[8]`=0xABCD.
- **Overflow.**
  - Stimulus: 9 stores with no pop (LOG_DEPTH=8).
  - Required: 8 entries retained; `log_overflow`=1 (sticky); a push and pop together when full keep occupancy at 8.
- **Halt and timeout.**
  - Stimulus: `halt_pc`=0x10 reached.
  - Required: `done`=1, `timeout`=0, `stall` stays 1.
  - Stimulus: MAX_CYCLES=16 with `pc` held at 0.
  - Required: `done`=1, `timeout`=1 at `retired`=16.
- **Async reset mid-WAIT.**
  - Stimulus: drop `n_rst` mid-WAIT.
  - Required: immediate `stall`=1, `inst`=NOP, FIFO empty, `retired`=0; a new `start` replays from imem[0].
